sensor_poll_scheduler: RTL

- Sequences periodic sweeps of all eight greenhouse sensors over one shared I2C master command port: four lux sensors (N/E/S/W), then four temperature sensors (solar/greenhouse/ambient/geothermal).
- Issues one command at a time with a valid/ready handshake, waits for the response with a timeout and bounded retry, and latches results into held output registers.
- Feeds the solar tracker, hc/temp_control and seven-segment blocks; sits between the I2C clock domain master and the consumers. Single clock.

---
 rtl/sensor_poll_scheduler_pkg.sv | 42 ++++
 rtl/sensor_poll_scheduler_if.sv | 21 ++
 rtl/sensor_poll_scheduler_timer.sv | 34 +++
 rtl/sensor_poll_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_poll_scheduler_pkg.sv
// Shared types and constants for the greenhouse sensor poll scheduler.
// Slot order: four lux sensors (N/E/S/W) followed by four temperature sensors.
package greenhouse_sensor_pkg;

    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_N     = 3'd0;
    localparam slot_t SLOT_E     = 3'd1;
    localparam slot_t SLOT_S     = 3'd2;
    localparam slot_t SLOT_W     = 3'd3;
    localparam slot_t SLOT_SOLAR = 3'd4;
    localparam slot_t SLOT_GH    = 3'd5;
    localparam slot_t SLOT_AMB   = 3'd6;
    localparam slot_t SLOT_GEO   = 3'd7;

    // 7-bit I2C slave address of each slot
    localparam logic [6:0] SLOT_ADDR [0:7] = '{
        7'h23, 7'h5C, 7'h29, 7'h39,
        7'h48, 7'h49, 7'h4A, 7'h4B
    };

    // Register pointer read on each slot (lux data register / temperature register)
    localparam logic [7:0] SLOT_REG [0:7] = '{
        8'h10, 8'h10, 8'hAC, 8'hAC,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RETRY = 3'd3,
        ST_STORE = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    // Lux slots are 0-3, temperature slots 4-7
    function automatic logic is_lux_slot(input slot_t s);
        return ~s[2];
    endfunction

endpackage

// File: rtl/sensor_poll_scheduler_if.sv
// Command/response port between the poll scheduler and the shared I2C master.
// master: the scheduler (issues commands); slave: the I2C master engine.
interface sensor_poll_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_reg;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;

    modport master (
        output cmd_valid, cmd_addr, cmd_reg,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_reg,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/sensor_poll_scheduler_timer.sv
// poll_interval_timer: free-running down counter that emits a one-cycle tick
// every POLL_INTERVAL cycles; the first tick comes POLL_INTERVAL cycles after reset.
module poll_interval_timer #(
    parameter int unsigned POLL_INTERVAL = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int unsigned CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload on zero, otherwise count down
    always_comb begin
        if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: sweeps eight greenhouse sensors over one I2C command
// port with timeout and bounded retry, holding the latest value of each.
// Optional feature macro: SENSOR_LUX_FILTER_EN (IIR smoothing of lux samples).
module sensor_poll_scheduler
    import greenhouse_sensor_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL  = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    sensor_poll_scheduler_if.master  bus,
    output logic [15:0]              n_lux,
    output logic [15:0]              e_lux,
    output logic [15:0]              s_lux,
    output logic [15:0]              w_lux,
    output logic [7:0]               solar_celcius,
    output logic [7:0]               greenhouse_celcius,
    output logic [7:0]               ambient_celcius,
    output logic [7:0]               geothermal_celcius,
    output logic [7:0]               sensor_fault,
    output logic                     sweep_done,
    output logic                     sweep_overrun
);
    localparam int unsigned AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // WAIT lasts at most TIMEOUT_CYCLES cycles: counter values 0 .. TIMEOUT_CYCLES-1
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          tick_s;
    state_t        state_q, state_d;
    slot_t         slot_q, slot_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic [TW-1:0] to_q, to_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   lux_q [0:3];
    logic [15:0]   lux_d [0:3];
    logic [7:0]    temp_q [0:3];
    logic [7:0]    temp_d [0:3];
    logic [7:0]    fault_q, fault_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   lux_new_s;

    poll_interval_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

`ifdef SENSOR_LUX_FILTER_EN
    logic [3:0]         seen_q;
    logic signed [17:0] diff_s, step_s, sum_s;

    // IIR step a quarter of the way toward the sample; first sample loads raw
    always_comb begin
        diff_s = $signed({2'b00, data_q}) - $signed({2'b00, lux_q[slot_q[1:0]]});
        step_s = diff_s >>> 2;
        sum_s  = $signed({2'b00, lux_q[slot_q[1:0]]}) + step_s;
        if (seen_q[slot_q[1:0]]) begin
            lux_new_s = sum_s[15:0];
        end else begin
            lux_new_s = data_q;
        end
    end

    // Per-slot "has a good sample since reset" flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_q <= 4'b0000;
        end else if ((state_q == ST_STORE) && is_lux_slot(slot_q)) begin
            seen_q <= seen_q | (4'b0001 << slot_q[1:0]);
        end else begin
            seen_q <= seen_q;
        end
    end
`else
    // Unfiltered: the sample replaces the held lux value
    always_comb begin
        lux_new_s = data_q;
    end
`endif

    // Next-state logic of the sweep FSM and all datapath registers
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        attempt_d = attempt_q;
        to_d      = to_q;
        data_d    = data_q;
        lux_d     = lux_q;
        temp_d    = temp_q;
        fault_d   = fault_q;
        done_d    = 1'b0;

        // A tick that finds a sweep in progress is dropped and flagged
        if (tick_s && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d   = ST_ISSUE;
                    slot_d    = SLOT_N;
                    attempt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d = ST_WAIT;
                    to_d    = '0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.rsp_valid && !bus.rsp_err) begin
                    data_d  = bus.rsp_data;
                    state_d = ST_STORE;
                end else if (bus.rsp_valid || (to_q == TO_LAST)) begin
                    state_d = ST_RETRY;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_RETRY: begin
                if (attempt_q < AW'(MAX_RETRY)) begin
                    attempt_d = attempt_q + AW'(1);
                    state_d   = ST_ISSUE;
                end else begin
                    fault_d[slot_q] = 1'b1;
                    state_d         = ST_NEXT;
                end
            end
            ST_STORE: begin
                if (is_lux_slot(slot_q)) begin
                    lux_d[slot_q[1:0]] = lux_new_s;
                end else begin
                    temp_d[slot_q[1:0]] = data_q[15:8];
                end
                fault_d[slot_q] = 1'b0;
                state_d         = ST_NEXT;
            end
            ST_NEXT: begin
                attempt_d = '0;
                if (slot_q == SLOT_GEO) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sweep immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= SLOT_N;
            attempt_q <= '0;
            to_q      <= '0;
            data_q    <= 16'h0000;
            lux_q     <= '{default: 16'h0000};
            temp_q    <= '{default: 8'h00};
            fault_q   <= 8'h00;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            attempt_q <= attempt_d;
            to_q      <= to_d;
            data_q    <= data_d;
            lux_q     <= lux_d;
            temp_q    <= temp_d;
            fault_q   <= fault_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Command fields come straight from registers so they stay stable in ISSUE
    assign bus.cmd_valid = (state_q == ST_ISSUE);
    assign bus.cmd_addr  = SLOT_ADDR[slot_q];
    assign bus.cmd_reg   = SLOT_REG[slot_q];

    assign n_lux              = lux_q[0];
    assign e_lux              = lux_q[1];
    assign s_lux              = lux_q[2];
    assign w_lux              = lux_q[3];
    assign solar_celcius      = temp_q[0];
    assign greenhouse_celcius = temp_q[1];
    assign ambient_celcius    = temp_q[2];
    assign geothermal_celcius = temp_q[3];
    assign sensor_fault       = fault_q;
    assign sweep_done         = done_q;
    assign sweep_overrun      = overrun_q;
endmodule
